// File: rtl/subckt_eval_pkg.sv
// Shared definitions for the sub-circuit evaluation arbiter: operand layout,
// the shared evaluation function and a small popcount helper.
package subckt_eval_pkg;

   localparam int OP_W   = 4;
   localparam int N1_BIT = 0;
   localparam int N2_BIT = 1;
   localparam int N3_BIT = 2;
   localparam int N4_BIT = 3;

   function automatic logic eval_f(input logic [OP_W-1:0] a);
      return (a[N1_BIT] & (a[N2_BIT] ^ a[N4_BIT])) ^ (a[N2_BIT] & a[N3_BIT]);
   endfunction

   function automatic logic [2:0] popcount4(input logic [OP_W-1:0] a);
      return 3'(a[0]) + 3'(a[1]) + 3'(a[2]) + 3'(a[3]);
   endfunction

endpackage

// File: rtl/subckt_eval_arbiter_rr_arb.sv
// Round-robin arbiter: circular lowest-index search starting at the pointer,
// pointer moves to one past the winner only when the grant is taken.
module rr_arb #(
   parameter int N = 4,
   localparam int ID_W = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            en,
   input  logic            advance,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx
);

   logic [ID_W-1:0] ptr_q;
   logic            found;

   always_comb begin
      int j;
      j         = 0;
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found     = 1'b1;
            grant_idx = ID_W'(j);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (found && en) grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance) begin
         ptr_q <= (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + ID_W'(1);
      end
   end

endmodule

// File: rtl/subckt_eval_arbiter.sv
// Shares one evaluation cone among NREQ requesters with operand isolation
// and a saturating toggle counter on the shared operand register.
module subckt_eval_arbiter
   import subckt_eval_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int CNT_W = 16,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [4*NREQ-1:0]    req_ops,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_data,
   output logic [ID_W-1:0]      rsp_id,
   input  logic                 tog_clr,
   output logic [CNT_W-1:0]     tog_cnt
);

   logic            can_accept;
   logic            accept;
   logic [ID_W-1:0] grant_idx;
   logic [OP_W-1:0] acc_ops;
   logic [OP_W-1:0] op_q;
   logic [CNT_W:0]  tog_sum;
   logic [CNT_W-1:0] tog_next;

   // Holding grants off while in reset keeps req_ready low during reset.
   assign can_accept = (!rsp_valid | rsp_ready) & rst_n;
   assign accept     = |(req_ready & req_valid);
   assign acc_ops    = req_ops[{grant_idx, 2'b00} +: OP_W];

   rr_arb #(.N(NREQ)) u_rr_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .en        (can_accept),
      .advance   (accept),
      .grant     (req_ready),
      .grant_idx (grant_idx)
   );

   always_comb begin
      tog_sum  = {1'b0, tog_cnt} + (CNT_W+1)'(popcount4(op_q ^ acc_ops));
      tog_next = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= 1'b0;
         rsp_id    <= '0;
      end else if (accept) begin
         op_q      <= acc_ops;
         rsp_valid <= 1'b1;
         rsp_data  <= eval_f(acc_ops);
         rsp_id    <= grant_idx;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tog_cnt <= '0;
      end else if (tog_clr) begin
         tog_cnt <= '0;
      end else if (accept) begin
         tog_cnt <= tog_next;
      end
   end

endmodule

// File: tb/tb_subckt_eval_arbiter.sv
// Directed bench for subckt_eval_arbiter (NREQ=4, CNT_W=4 so saturation is reachable).
module tb_subckt_eval_arbiter;

   localparam int NREQ  = 4;
   localparam int CNT_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_ops;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_data;
   logic [1:0]        rsp_id;
   logic              tog_clr;
   logic [CNT_W-1:0]  tog_cnt;

   int checks = 0;
   int errors = 0;

   subckt_eval_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ops   (req_ops),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .tog_clr   (tog_clr),
      .tog_cnt   (tog_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic d,
                          input logic [1:0] id, input logic [3:0] cnt);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      chk({tag, "_data"},  32'(rsp_data),  32'(d));
      chk({tag, "_id"},    32'(rsp_id),    32'(id));
      chk({tag, "_tog"},   32'(tog_cnt),   32'(cnt));
   endtask

   // ops3=1111 (f=1), ops2=0101 (f=0), ops1=0000 (f=0), ops0=0011 (f=1)
   localparam logic [15:0] OPS_MIX = 16'b1111_0101_0000_0011;

   logic [1:0] fair_id  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
   logic       fair_dat [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [3:0] fair_tog [5] = '{4'd4, 4'd6, 4'd8, 4'd10, 4'd12};
   logic [3:0] sat_tog  [5] = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
   logic       sat_dat  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_ops   = '0;
      rsp_ready = 1'b0;
      tog_clr   = 1'b0;
      tick();
      tick();
      chk_rsp("reset", 1'b0, 1'b0, 2'd0, 4'd0);
      rst_n = 1'b1;

      // single request from requester 0
      req_valid = 4'b0001;
      req_ops   = OPS_MIX;
      rsp_ready = 1'b1;
      #1;
      chk("single_ready", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      chk_rsp("single", 1'b1, 1'b1, 2'd0, 4'd2);
      tick();
      chk("single_drain", 32'(rsp_valid), 32'd0);

      // fairness, pointer starts at 1
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("fair_ready", 32'(req_ready), 32'(4'b0001 << fair_id[k]));
         tick();
         chk_rsp("fair", 1'b1, fair_dat[k], fair_id[k], fair_tog[k]);
      end

      // back-pressure with requesters 1 and 2 waiting, pointer at 2
      req_valid = 4'b0110;
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'b0000);
         tick();
         chk_rsp("bp_hold", 1'b1, 1'b0, 2'd1, 4'd12);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0100);
      tick();
      chk_rsp("bp_release", 1'b1, 1'b0, 2'd2, 4'd14);

      // wrap: pointer at 3, requesters 3 and 0
      req_valid = 4'b1001;
      #1;
      chk("wrap_ready3", 32'(req_ready), 32'b1000);
      tick();
      chk_rsp("wrap3", 1'b1, 1'b1, 2'd3, 4'd15);
      #1;
      chk("wrap_ready0", 32'(req_ready), 32'b0001);
      tick();
      chk_rsp("wrap0", 1'b1, 1'b1, 2'd0, 4'd15);

      // idle cycle must not move the pointer (stays 1, so 3 wins over 0)
      req_valid = '0;
      tick();
      chk("idle_valid", 32'(rsp_valid), 32'd0);
      req_valid = 4'b1001;
      tog_clr   = 1'b1;
      #1;
      chk("idle_ptr_ready", 32'(req_ready), 32'b1000);
      tick();
      tog_clr = 1'b0;
      chk_rsp("clr_accept", 1'b1, 1'b1, 2'd3, 4'd0);

      // asynchronous reset mid-traffic with a pending response
      req_valid = 4'b1111;
      rsp_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_rsp("async_reset", 1'b0, 1'b0, 2'd0, 4'd0);
      chk("async_reset_ready", 32'(req_ready), 32'b0000);
      tick();
      req_valid = '0;
      rst_n     = 1'b1;
      tick();
      chk("post_reset_valid", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("post_reset_ready", 32'(req_ready), 32'b0001);

      // saturation: requester 0 alternates 1111 / 0000
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         req_ops[3:0] = (k % 2 == 0) ? 4'b1111 : 4'b0000;
         #1;
         tick();
         chk_rsp("sat", 1'b1, sat_dat[k], 2'd0, sat_tog[k]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/subckt_eval_arbiter.md
Name: subckt_eval_arbiter

Overview:
- Shares one instance of the 4-input evaluation function `f` among NREQ requesters.
- Arbitration is round-robin.
- Operands are isolated: the operand register only changes when a request is accepted, so the shared logic does not toggle while idle.
- A saturating toggle counter reports how many operand bits changed at the shared unit's inputs, for power-experiment monitoring.
- Sits between the requester datapaths and the shared logic cone in the power sub-circuit experiments.

Parameters:
- NREQ, 4, number of requesters (2..16).
- CNT_W, 16, width of the toggle counter.
- ID_W, $clog2(NREQ), derived localparam; width of the requester ID.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_ops  in  4*NREQ  operands of requester i at [4i+3:4i]; bit0=n_1, bit1=n_2, bit2=n_3, bit3=n_4.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_data  out  1  f(ops) of the accepted request.
- rsp_id  out  ID_W  index of the requester the result belongs to.
- tog_clr  in  1  synchronous clear of tog_cnt.
- tog_cnt  out  CNT_W  saturating count of operand-register bit toggles.

Behaviour:
- Function: f(a) = (a0 & (a1 ^ a3)) ^ (a1 & a2). Examples: f(4'b0011)=1, f(4'b1111)=1, f(4'b0000)=0, f(4'b0101)=0.
- Reset (async, rst_n=0) clears immediately:
  - rsp_valid=0, rsp_data=0, rsp_id=0, tog_cnt=0.
  - Operand register op_q=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
- Reset mid-operation discards any pending result; no response is produced for it after release.
- can_accept = !rsp_valid | rsp_ready. This allows a pipelined one-per-cycle throughput.
- Grant: the lowest-index valid requester, searching circularly from the pointer.
  - req_ready[i] = grant[i] & can_accept. It is combinational from req_valid, the pointer and rsp_valid/rsp_ready.
  - No grant is made when no requester is valid.
- Accept cycle N is any cycle with req_valid[i] & req_ready[i]. On accept:
  - op_q <= ops_i.
  - Result register <= f(ops_i), id <= i, rsp_valid <= 1. The response is visible in cycle N+1 (latency 1).
  - Pointer <= (i+1) mod NREQ; NREQ-1 wraps to 0.
- No accept with rsp_ready=1 and rsp_valid=1: rsp_valid <= 0.
- No accept with rsp_ready=0: rsp_valid, rsp_data, rsp_id, op_q and the pointer all hold.
- Requesters must hold valid and ops stable until accepted. The arbiter re-arbitrates every cycle and has no lock.
- Operand isolation: op_q changes only on accept. rsp_data is registered, never combinational from req_ops.
- Toggle counter: on accept, tog_cnt <= min(tog_cnt + popcount(op_q ^ ops_i), 2^CNT_W-1). It holds otherwise.
- tog_clr=1 sets tog_cnt <= 0. It takes priority over a same-cycle increment, which is discarded.

Decomposition:
- Package subckt_eval_pkg holds:
  - localparam OP_W=4;
  - bit-index constants for n_1..n_4;
  - function eval_f(logic [3:0]) returning f;
  - function popcount4.
- Sub-module rr_arb (parameter N):
  - inputs: req, en, advance;
  - outputs: one-hot grant, grant index;
  - owns the pointer register (async reset to 0).
- The top level holds the operand and result registers and the toggle counter.

Test Plan:
- Reset: rst_n=0 mid-traffic with rsp_valid=1 -> rsp_valid drops to 0 the same cycle without a clock edge; tog_cnt=0, req_ready=0; after release the first grant goes to requester 0.
- Single request: req_valid=0001, ops0=4'b0011, rsp_ready=1 -> req_ready=0001 in cycle N; cycle N+1 gives rsp_valid=1, rsp_data=1, rsp_id=0; tog_cnt=2.
- Fairness: req_valid=1111 held, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one response per cycle, rsp_id sequence 0,1,2,3,0.
- Back-pressure: rsp_valid=1, rsp_ready=0 for 3 cycles with requesters 1 and 2 valid -> req_ready=0000; rsp_data, rsp_id and tog_cnt stable. When rsp_ready rises, the next requester is accepted that cycle and its result appears the following cycle.
- Saturation (CNT_W=4): requester 0 alternates ops 1111/0000 -> tog_cnt 4,8,12,15,15 and rsp_data 1,0,1,0,1. tog_clr=1 together with an accept -> tog_cnt=0.
- Wrap: NREQ=4, pointer at 3, req_valid=1001 -> grant 3 and then 0; an idle cycle with no valid requests leaves the pointer unchanged.
